param_register_block: RTL and testbench
=======================================

PARAM_REGISTER_BLOCK -- requirements
Module: param_register_block

Interface
REQ-001 Parameter ADDR_W, default 4; register count NUM_REGS = 2**ADDR_W, legal range 2..6.
REQ-002 Parameter DATA_W, default 32; register and bus width, legal range 16..64.
REQ-003 Parameter RO_MASK, NUM_REGS bits, default 16'h0082; bit i=1 makes register i read-only, sourced from ro_data.
REQ-004 Port clk  in  1  sole clock.
REQ-005 Port reset  in  1  asynchronous, active-high reset.
REQ-006 Port rx_data  in  DATA_W  write data or register-number word.
REQ-007 Port reg_num_le  in  1  load pointer/mode from rx_data.
REQ-008 Port wr_en / rd_en  in  1 each  single-cycle access strobes.
REQ-009 Port tx_data  out  DATA_W  registered read data; tx_valid  out  1  read-data qualifier.
REQ-010 Port illegal_reg_num  out  1  pointer field out of range.
REQ-011 Port regs_out  out  NUM_REGS*DATA_W  flattened RW contents, register i at slice i.
REQ-012 Port ro_data  in  NUM_REGS*DATA_W  read-only sources (only RO_MASK slices used).
REQ-013 Port wr_strobe  out  NUM_REGS  one-hot write pulse per register.
REQ-014 Port err_clr  in  1; err_sticky  out  1; err_count  out  16  rejected-access status.

Function
REQ-015 On reg_num_le, pointer SHALL load rx_data[ADDR_W-1:0], inc_mode SHALL load rx_data[DATA_W-1], range field rx_data[DATA_W-2:ADDR_W] SHALL be held.
REQ-016 illegal_reg_num SHALL be 1 whenever the held range field is non-zero.
REQ-017 Legal wr_en to an RW register SHALL update it on the next clock edge; wr_strobe[ptr] SHALL pulse combinationally in the wr_en cycle.
REQ-018 wr_en to an RO register or while illegal SHALL be rejected: no register change, no wr_strobe.
REQ-019 rd_en SHALL produce tx_data one cycle later with tx_valid high for exactly that cycle; tx_data SHALL hold otherwise.
REQ-020 Read of RW register returns its pre-edge value; read of RO register returns the ro_data slice sampled in the rd_en cycle; illegal read returns the low DATA_W bits of 32'hDEAD_BEEF (zero-extended if wider) and counts as rejected.
REQ-021 With inc_mode=1, every rd_en or wr_en cycle (accepted or rejected, illegal excluded) SHALL advance pointer by one, wrapping NUM_REGS-1 -> 0.
REQ-022 rd_en and wr_en in the same cycle: write applies, read returns pre-write value, pointer advances once.
REQ-023 reg_num_le with rd_en or wr_en in the same cycle: load wins, access dropped, counted as rejected, tx_valid stays low.
REQ-024 Each rejected access SHALL set err_sticky and increment err_count, saturating at 16'hFFFF.
REQ-025 err_clr SHALL clear err_sticky and err_count next edge; a coincident rejection SHALL leave err_count=1, err_sticky=1.

Reset
REQ-026 reset SHALL asynchronously clear all RW registers, pointer, inc_mode, range field, tx_data, tx_valid, err_sticky, err_count to 0.
REQ-027 wr_strobe SHALL be 0 while reset is high; accesses during reset are discarded and not counted.
REQ-028 Reset mid-burst SHALL abandon the burst; next access requires a new reg_num_le.

Structure
REQ-029 Package reg_block_pkg SHALL hold ILLEGAL_RD_VAL (32'hDEAD_BEEF), ERR_CNT_W (16), and the default RO_MASK.
REQ-030 Pointer load, range check and auto-increment SHALL live in one sub-module reg_addr_ptr; the register array, read mux and error counters stay in the top.

Verification
REQ-031 Load 0x0000_0003, write 0x1234_5678, load 0x3, read -> tx_data=0x1234_5678, tx_valid one cycle after rd_en, wr_strobe=16'h0008 for one cycle.
REQ-032 Load 0x8000_000E, write 0xA,0xB,0xC -> reg14=0xA, reg15=0xB, reg0=0xC (wrap); pointer ends at 1.
REQ-033 Load 0x1, write 0xFFFF_FFFF, ro_data slice1=0x55 -> reg1 unchanged, read returns 0x55, err_sticky=1, err_count=1.
REQ-034 Load 0x0000_0010, read -> illegal_reg_num=1, tx_data=0xDEAD_BEEF, err_count increments; then err_clr with coincident rejected write -> err_count=1.
REQ-035 Load 0x2, simultaneous wr_en(0x99) and rd_en on reg2 holding 0x11 -> tx_data=0x11, reg2=0x99; then assert reset mid-burst -> all outputs 0 immediately.

Source files
------------

// File: rtl/reg_block_pkg.sv
// Shared constants for the parameterised register block.
package reg_block_pkg;

    // Value returned when the held pointer range field is non-zero.
    localparam logic [31:0] ILLEGAL_RD_VAL = 32'hDEAD_BEEF;

    // Width of the rejected-access counter.
    localparam int unsigned ERR_CNT_W = 16;

    // Registers 1 and 7 are read-only in the default 16-register build.
    localparam logic [15:0] DEFAULT_RO_MASK = 16'h0082;

endpackage : reg_block_pkg

// File: rtl/reg_addr_ptr.sv
// Register pointer: loads from a register-number word, flags a non-zero
// range field as illegal, and auto-increments on accesses in inc mode.
module reg_addr_ptr #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              load_i,
    input  logic              access_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              inc_mode_o,
    output logic              illegal_o
);

    localparam int unsigned RANGE_W = DATA_W - 1 - ADDR_W;

    logic [ADDR_W-1:0]  ptr_q,   ptr_d;
    logic               inc_q,   inc_d;
    logic [RANGE_W-1:0] range_q, range_d;

    // Load takes priority; otherwise advance on any non-illegal access in inc mode.
    always_comb begin
        ptr_d   = ptr_q;
        inc_d   = inc_q;
        range_d = range_q;
        if (load_i) begin
            ptr_d   = rx_data_i[ADDR_W-1:0];
            inc_d   = rx_data_i[DATA_W-1];
            range_d = rx_data_i[DATA_W-2:ADDR_W];
        end else if (access_i && inc_q && (range_q == '0)) begin
            // Power-of-two register count, so natural overflow wraps to 0.
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    // Pointer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= '0;
            inc_q   <= 1'b0;
            range_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            inc_q   <= inc_d;
            range_q <= range_d;
        end
    end

    assign ptr_o      = ptr_q;
    assign inc_mode_o = inc_q;
    assign illegal_o  = (range_q != '0);

endmodule : reg_addr_ptr

// File: rtl/param_register_block.sv
// Parameterised register file with pointer-based access, read-only slots,
// registered read data and rejected-access error tracking.
module param_register_block
    import reg_block_pkg::*;
#(
    parameter int unsigned               ADDR_W  = 4,
    parameter int unsigned               DATA_W  = 32,
    parameter logic [(2**ADDR_W)-1:0]    RO_MASK = DEFAULT_RO_MASK
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_W-1:0]               rx_data,
    input  logic                            reg_num_le,
    input  logic                            wr_en,
    input  logic                            rd_en,
    output logic [DATA_W-1:0]               tx_data,
    output logic                            tx_valid,
    output logic                            illegal_reg_num,
    output logic [(2**ADDR_W)*DATA_W-1:0]   regs_out,
    input  logic [(2**ADDR_W)*DATA_W-1:0]   ro_data,
    output logic [(2**ADDR_W)-1:0]          wr_strobe,
    input  logic                            err_clr,
    output logic                            err_sticky,
    output logic [ERR_CNT_W-1:0]            err_count
);

    localparam int unsigned NUM_REGS = 2**ADDR_W;

    logic [ADDR_W-1:0] ptr;
    logic              inc_mode;
    logic              illegal;

    logic              access;
    logic              ptr_ro;
    logic              wr_go;
    logic              rd_go;
    logic              wr_ok;
    logic              reject;
    logic [DATA_W-1:0] rd_val;

    logic [DATA_W-1:0]    regs_q [NUM_REGS];
    logic [DATA_W-1:0]    regs_d [NUM_REGS];
    logic [DATA_W-1:0]    tx_data_q,  tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 sticky_q,   sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q,      cnt_d;

    assign access = rd_en | wr_en;

    // Pointer, range check and auto-increment.
    reg_addr_ptr #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ptr (
        .clk        (clk),
        .reset      (reset),
        .rx_data_i  (rx_data),
        .load_i     (reg_num_le),
        .access_i   (access),
        .ptr_o      (ptr),
        .inc_mode_o (inc_mode),
        .illegal_o  (illegal)
    );

    // Access qualification; a coincident pointer load drops the access.
    always_comb begin
        ptr_ro = RO_MASK[ptr];
        wr_go  = wr_en & ~reg_num_le;
        rd_go  = rd_en & ~reg_num_le;
        wr_ok  = wr_go & ~illegal & ~ptr_ro;
        reject = (reg_num_le & access)
               | (wr_go & (illegal | ptr_ro))
               | (rd_go & illegal);
    end

    // Read mux: illegal marker, read-only source, or stored value.
    always_comb begin
        rd_val = regs_q[ptr];
        if (illegal) begin
            rd_val = DATA_W'(ILLEGAL_RD_VAL);
        end else if (ptr_ro) begin
            rd_val = ro_data[ptr*DATA_W +: DATA_W];
        end
    end

    // Register array next state; read-only slots are never written.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[ptr] = rx_data;
        end
    end

    // Read data capture; tx_data holds between reads.
    always_comb begin
        tx_data_d  = tx_data_q;
        tx_valid_d = rd_go;
        if (rd_go) begin
            tx_data_d = rd_val;
        end
    end

    // Error tracking: one count per cycle that carries a rejection, saturating.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (err_clr) begin
            sticky_d = reject;
            cnt_d    = reject ? ERR_CNT_W'(1) : '0;
        end else if (reject) begin
            sticky_d = 1'b1;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    // Write pulse for the addressed register, suppressed during reset.
    always_comb begin
        wr_strobe = '0;
        if (wr_ok && !reset) begin
            wr_strobe[ptr] = 1'b1;
        end
    end

    // Register array state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read and error status state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            sticky_q   <= sticky_d;
            cnt_q      <= cnt_d;
        end
    end

    // Flatten RW contents; read-only slots present zero.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_out[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : regs_q[g];
    end

    assign tx_data         = tx_data_q;
    assign tx_valid        = tx_valid_q;
    assign illegal_reg_num = illegal;
    assign err_sticky      = sticky_q;
    assign err_count       = cnt_q;

endmodule : param_register_block

// File: tb/tb_param_register_block.sv
// Directed bench for param_register_block (default 16 x 32 build).
module tb_param_register_block;

    localparam int unsigned ADDR_W   = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 16;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [DATA_W-1:0]            rx_data;
    logic                         reg_num_le;
    logic                         wr_en;
    logic                         rd_en;
    logic [DATA_W-1:0]            tx_data;
    logic                         tx_valid;
    logic                         illegal_reg_num;
    logic [NUM_REGS*DATA_W-1:0]   regs_out;
    logic [NUM_REGS*DATA_W-1:0]   ro_data;
    logic [NUM_REGS-1:0]          wr_strobe;
    logic                         err_clr;
    logic                         err_sticky;
    logic [15:0]                  err_count;

    int n_tests = 0;
    int n_fail  = 0;

    param_register_block #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RO_MASK (16'h0082)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_data         (rx_data),
        .reg_num_le      (reg_num_le),
        .wr_en           (wr_en),
        .rd_en           (rd_en),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .illegal_reg_num (illegal_reg_num),
        .regs_out        (regs_out),
        .ro_data         (ro_data),
        .wr_strobe       (wr_strobe),
        .err_clr         (err_clr),
        .err_sticky      (err_sticky),
        .err_count       (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic le, input logic wr, input logic rd,
                         input logic clr, input logic [DATA_W-1:0] d);
        reg_num_le = le;
        wr_en      = wr;
        rd_en      = rd;
        err_clr    = clr;
        rx_data    = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] reg_at(input int i);
        return regs_out[i*DATA_W +: DATA_W];
    endfunction

    initial begin
        ro_data = '0;
        ro_data[1*DATA_W +: DATA_W] = 32'h0000_0055;
        ro_data[7*DATA_W +: DATA_W] = 32'h0000_0777;

        // Reset with accesses pending: strobes suppressed, nothing counted.
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D);
        #12;
        chk("rst_wr_strobe", 64'(wr_strobe), 64'h0);
        chk("rst_tx_valid",  64'(tx_valid),  64'h0);
        chk("rst_tx_data",   64'(tx_data),   64'h0);
        chk("rst_regs_zero", 64'(regs_out == '0), 64'h1);
        tick();
        chk("rst_err_count", 64'(err_count), 64'h0);
        idle();
        reset = 1'b0;
        tick();
        chk("post_rst_err", 64'(err_sticky), 64'h0);

        // Basic write then read of reg3.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0003);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
        #1;
        chk("w3_strobe", 64'(wr_strobe), 64'h0008);
        tick();
        idle();
        #1;
        chk("w3_strobe_off", 64'(wr_strobe), 64'h0);
        chk("w3_reg", 64'(reg_at(3)), 64'h1234_5678);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0003);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        #1;
        chk("r3_valid_early", 64'(tx_valid), 64'h0);
        tick();
        idle();
        chk("r3_valid", 64'(tx_valid), 64'h1);
        chk("r3_data",  64'(tx_data),  64'h1234_5678);
        tick();
        chk("r3_valid_drop", 64'(tx_valid), 64'h0);
        chk("r3_data_hold",  64'(tx_data),  64'h1234_5678);

        // Auto-increment burst wrapping 14 -> 15 -> 0.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_000E);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000A);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000B);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_000C);
        tick();
        idle();
        chk("burst_r14", 64'(reg_at(14)), 64'hA);
        chk("burst_r15", 64'(reg_at(15)), 64'hB);
        chk("burst_r0",  64'(reg_at(0)),  64'hC);
        // Pointer now at 1 (read-only): a read returns its ro_data slice.
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        idle();
        chk("burst_ptr1", 64'(tx_data), 64'h55);

        // Write to read-only reg1 is rejected; read returns ro_data.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0001);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        #1;
        chk("ro_wr_strobe", 64'(wr_strobe), 64'h0);
        tick();
        idle();
        chk("ro_reg_unchanged", 64'(reg_at(1)), 64'h0);
        chk("ro_sticky", 64'(err_sticky), 64'h1);
        chk("ro_count",  64'(err_count),  64'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        idle();
        chk("ro_read", 64'(tx_data), 64'h55);

        // Illegal pointer read, then clear with coincident rejected write.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010);
        tick();
        idle();
        chk("ill_flag", 64'(illegal_reg_num), 64'h1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        tick();
        idle();
        chk("ill_read", 64'(tx_data), 64'hDEAD_BEEF);
        chk("ill_count", 64'(err_count), 64'h2);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0077);
        #1;
        chk("ill_wr_strobe", 64'(wr_strobe), 64'h0);
        tick();
        idle();
        chk("clr_coinc_count",  64'(err_count),  64'h1);
        chk("clr_coinc_sticky", 64'(err_sticky), 64'h1);
        chk("ill_reg0_kept", 64'(reg_at(0)), 64'hC);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();
        idle();
        chk("clr_count",  64'(err_count),  64'h0);
        chk("clr_sticky", 64'(err_sticky), 64'h0);

        // Load coincident with read: load wins, read dropped and counted.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0005);
        tick();
        idle();
        chk("coll_valid", 64'(tx_valid), 64'h0);
        chk("coll_count", 64'(err_count), 64'h1);
        chk("coll_legal", 64'(illegal_reg_num), 64'h0);

        // Simultaneous write and read of reg2.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0002);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0011);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0099);
        tick();
        idle();
        chk("rw_tx",    64'(tx_data),   64'h11);
        chk("rw_valid", 64'(tx_valid),  64'h1);
        chk("rw_reg2",  64'(reg_at(2)), 64'h99);

        // Reset in the middle of an auto-increment burst.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_0004);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0001);
        tick();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0002);
        tick();
        chk("mid_r5", 64'(reg_at(5)), 64'h2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0003);
        reset = 1'b1;
        #1;
        chk("mid_rst_tx",     64'(tx_data),    64'h0);
        chk("mid_rst_valid",  64'(tx_valid),   64'h0);
        chk("mid_rst_regs",   64'(regs_out == '0), 64'h1);
        chk("mid_rst_count",  64'(err_count),  64'h0);
        chk("mid_rst_sticky", 64'(err_sticky), 64'h0);
        chk("mid_rst_strobe", 64'(wr_strobe),  64'h0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        // Burst abandoned: pointer 0, inc mode off, so both writes hit reg0.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00AA);
        #1;
        chk("post_mid_strobe", 64'(wr_strobe), 64'h0001);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_00BB);
        tick();
        idle();
        chk("post_mid_r0", 64'(reg_at(0)), 64'hBB);
        chk("post_mid_r6", 64'(reg_at(6)), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_param_register_block
